smp_snoop_arbiter: RTL

Parametrised snooping-bus arbiter for the multicore processor. It generalises the two-core coherence bus to `NUM_CORES` caches. The block grants one cache miss or invalidate at a time, round-robin, and broadcasts it to all peer caches for MSI snooping. It then collects every peer's snoop acknowledgement, runs the memory fill for misses, and returns a one-hot completion pulse to the requester.

---
 rtl/smp_snoop_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/smp_snoop_arbiter.sv
// Round-robin snooping-bus arbiter: grants one miss/invalidate at a time, broadcasts it,
// collects peer snoop acks, runs the memory fill for misses and pulses a one-hot completion.
module smp_snoop_arbiter #(
  parameter int NUM_CORES     = 4,
  parameter int ADDR_W        = 16,
  parameter int SNOOP_TIMEOUT = 15,
  localparam int ID_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [2*NUM_CORES-1:0]      req_op,
  input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
  output logic                        bus_valid,
  output logic [1:0]                  bus_op,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [ID_W-1:0]             bus_src,
  input  logic [NUM_CORES-1:0]        snoop_ack,
  input  logic [NUM_CORES-1:0]        snoop_hit,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_rdy,
  output logic [NUM_CORES-1:0]        req_done,
  output logic                        req_shared,
  output logic                        snoop_err
);

  localparam int TO_W = $clog2(SNOOP_TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, MEM, DONE} state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       pick;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic [1:0]            op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [NUM_CORES-1:0]  ack_seen;
  logic [NUM_CORES-1:0]  hit_seen;
  logic [NUM_CORES-1:0]  grant_mask;
  logic [NUM_CORES-1:0]  ack_next;
  logic [NUM_CORES-1:0]  hit_next;
  logic [TO_W-1:0]       to_cnt;
  logic                  err_flag;
  logic                  ack_all;
  logic                  timed_out;
  logic                  is_miss;

  // First requester at or after rr_ptr, wrapping around the core ring.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_CORES);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The requester never snoops itself, so its own ack/hit bits are masked out.
  assign grant_mask = NUM_CORES'(1) << grant_id;
  assign ack_next   = ack_seen | snoop_ack;
  assign hit_next   = hit_seen | (snoop_hit & snoop_ack & ~grant_mask);
  assign ack_all    = &(ack_next | grant_mask);
  assign timed_out  = (to_cnt == TO_W'(SNOOP_TIMEOUT));
  assign is_miss    = ~op_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      ack_seen   <= '0;
      hit_seen   <= '0;
      to_cnt     <= '0;
      err_flag   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_op     <= '0;
      bus_addr   <= '0;
      bus_src    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      req_done   <= '0;
      req_shared <= 1'b0;
      snoop_err  <= 1'b0;
    end else begin
      bus_valid  <= 1'b0;
      req_done   <= '0;
      req_shared <= 1'b0;
      snoop_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= pick;
            op_q      <= req_op[int'(pick)*2 +: 2];
            addr_q    <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
            bus_valid <= 1'b1;
            bus_op    <= req_op[int'(pick)*2 +: 2];
            bus_addr  <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
            bus_src   <= pick;
            state     <= BCAST;
          end
        end
        BCAST: begin
          ack_seen <= '0;
          hit_seen <= '0;
          to_cnt   <= '0;
          err_flag <= 1'b0;
          state    <= SNOOP;
        end
        SNOOP: begin
          ack_seen <= ack_next;
          hit_seen <= hit_next;
          to_cnt   <= to_cnt + 1'b1;
          // On timeout the missing acks are abandoned and the op proceeds as usual.
          if (ack_all || timed_out) begin
            err_flag <= ~ack_all;
            if (is_miss) begin
              mem_req  <= 1'b1;
              mem_addr <= addr_q;
              state    <= MEM;
            end else begin
              req_done   <= grant_mask;
              req_shared <= |hit_next;
              snoop_err  <= ~ack_all;
              state      <= DONE;
            end
          end
        end
        MEM: begin
          if (mem_rdy) begin
            mem_req    <= 1'b0;
            req_done   <= grant_mask;
            req_shared <= |hit_seen;
            snoop_err  <= err_flag;
            state      <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= (grant_id == ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
